// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse
//   Multi-channel push-button conditioner feeding the PWM duty controls.
//   Each channel synchronises a raw pad input, accepts a new level only after
//   DEB_CYCLES consecutive stable samples, and emits a one-cycle press pulse
//   on every accepted 0->1 transition.
//
//   Optional feature macro: BTN_AUTOREPEAT_EN
//     defined   : a held button re-pulses after REPEAT_DELAY cycles, then
//                 every REPEAT_PERIOD cycles until release.
//     undefined : exactly one pulse per accepted press, no hold counter.
//
// Ports
//   clk        system clock
//   reset      asynchronous assert, synchronous release, active high
//   btn_raw    raw asynchronous button inputs, active high (NCH bits)
//   btn_level  debounced level per channel (registered)
//   btn_pulse  one-cycle press pulse per channel (registered)
// ---------------------------------------------------------------------------
module btn_debounce_pulse #(
  parameter int unsigned NCH           = 2,
  parameter int unsigned DEB_CYCLES    = 1000,
  parameter int unsigned CW            = 16,
  parameter int unsigned REPEAT_DELAY  = 5000000,
  parameter int unsigned REPEAT_PERIOD = 1000000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] btn_raw,
  output logic [NCH-1:0] btn_level,
  output logic [NCH-1:0] btn_pulse
);

`ifdef BTN_AUTOREPEAT_EN
  localparam bit REPEAT_USED = 1'b1;
`else
  localparam bit REPEAT_USED = 1'b0;
`endif

  // Counters must be able to hold every terminal value they compare against;
  // repeat timing only constrains CW when the repeat feature is built.
  localparam logic [63:0] CNT_RANGE = 64'(1) << CW;
  localparam bit DEB_OK    = (DEB_CYCLES >= 2) && (CNT_RANGE > 64'(DEB_CYCLES));
  localparam bit REPEAT_OK = !REPEAT_USED ||
                             ((REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1) &&
                              (CNT_RANGE > 64'(REPEAT_DELAY)) &&
                              (CNT_RANGE > 64'(REPEAT_PERIOD)));

  if (!(DEB_OK && REPEAT_OK)) begin : g_bad_cfg
    $error("btn_debounce_pulse: CW too small or timing parameters out of range");
  end

  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

  // Two-flop synchroniser; only s2 is used downstream.
  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          pulse_q;
    logic          pulse_d;

    // Stability counter: any sample equal to the current level restarts the
    // window, so only an unbroken DEB_CYCLES run of the new level is accepted.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (s2_q[i] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DEB_LAST) begin
        level_d = s2_q[i];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CW-1:0] RPT_FIRST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RPT_NEXT  = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] hold_q;
    logic [CW-1:0] hold_d;
    logic          rep_q;
    logic          rep_d;

    // Hold timer: counts cycles since the last pulse while the level stays
    // high. Looking at level_d lets a release suppress a repeat on that edge.
    always_comb begin
      hold_d  = hold_q;
      rep_d   = rep_q;
      pulse_d = 1'b0;
      if (!level_d) begin
        hold_d = '0;
        rep_d  = 1'b0;
      end else if (!level_q) begin
        pulse_d = 1'b1;
        hold_d  = '0;
        rep_d   = 1'b0;
      end else if (!rep_q && (hold_q == RPT_FIRST)) begin
        pulse_d = 1'b1;
        hold_d  = '0;
        rep_d   = 1'b1;
      end else if (rep_q && (hold_q == RPT_NEXT)) begin
        pulse_d = 1'b1;
        hold_d  = '0;
      end else begin
        hold_d = hold_q + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_q <= '0;
        rep_q  <= 1'b0;
      end else begin
        hold_q <= hold_d;
        rep_q  <= rep_d;
      end
    end
`else
    // Pulse only on the edge where the accepted level rises.
    always_comb begin
      pulse_d = ~level_q & level_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
      end
    end

    assign btn_level[i] = level_q;
    assign btn_pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_pulse
//   Directed bench for btn_debounce_pulse with DEB_CYCLES=4, REPEAT_DELAY=8,
//   REPEAT_PERIOD=3. Per-cycle vectors are applied one clock apart: raw is
//   driven 1 time unit after a rising edge and outputs are checked 1 time
//   unit after the following rising edge.
// ---------------------------------------------------------------------------
module tb_btn_debounce_pulse;

  typedef struct packed {
    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] pls;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_pulse;

  int n_vec;
  int n_err;
  vec_t tbl[$];

  btn_debounce_pulse #(
    .NCH          (2),
    .DEB_CYCLES   (4),
    .CW           (8),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic [1:0] r, input logic [1:0] l,
                     input logic [1:0] p, input int n);
    for (int k = 0; k < n; k++) tbl.push_back({r, l, p});
  endtask

  task automatic check(input string name, input int idx,
                       input logic [1:0] l, input logic [1:0] p);
    n_vec++;
    if (btn_level !== l || btn_pulse !== p) begin
      n_err++;
      $display("FAIL %s[%0d]: level=%b pulse=%b, expected level=%b pulse=%b",
               name, idx, btn_level, btn_pulse, l, p);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_p;
    logic [1:0] exp_l;
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    btn_raw = 2'b00;

    // Test 1 + 4: ch0 press accepted 5 edges after first sample, one pulse;
    // release accepted 5 edges later with no pulse.
    add(2'b01, 2'b00, 2'b00, 5);
    add(2'b01, 2'b01, 2'b01, 1);
    add(2'b01, 2'b01, 2'b00, 2);
    add(2'b00, 2'b01, 2'b00, 5);
    add(2'b00, 2'b00, 2'b00, 2);
    // Test 2: 3-cycle glitch is one short of the window and is rejected.
    add(2'b01, 2'b00, 2'b00, 3);
    add(2'b00, 2'b00, 2'b00, 5);
    // Test 3: ch1 bounce 1,0,1,1,0 then held; accepted after final 4-run.
    add(2'b10, 2'b00, 2'b00, 1);
    add(2'b00, 2'b00, 2'b00, 1);
    add(2'b10, 2'b00, 2'b00, 2);
    add(2'b00, 2'b00, 2'b00, 1);
    add(2'b10, 2'b00, 2'b00, 5);
    add(2'b10, 2'b10, 2'b10, 1);
    add(2'b10, 2'b10, 2'b00, 2);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, 2'b00, 2'b00);
    reset = 1'b0;

    foreach (tbl[i]) begin
      btn_raw = tbl[i].raw;
      step();
      check("vec", i, tbl[i].lvl, tbl[i].pls);
    end

    // Test 5: ch1 still high; press ch0 and reset with its count at 2.
    btn_raw = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t5_pre", k, 2'b10, 2'b00);
    end
    reset = 1'b1;
    #1;
    check("t5_async_rst", 0, 2'b00, 2'b00);
    step();
    check("t5_in_rst", 0, 2'b00, 2'b00);
    reset = 1'b0;
    // Fresh window from the first post-reset edge: both channels together.
    for (int k = 0; k < 5; k++) begin
      step();
      check("t5_window", k, 2'b00, 2'b00);
    end
    step();
    check("t5_accept", 0, 2'b11, 2'b11);
    step();
    check("t5_after", 0, 2'b11, 2'b00);

    // Test 6: ch0 held past acceptance, raw released so level falls at +23.
    btn_raw = 2'b00;
    repeat (8) step();
    check("t6_idle", 0, 2'b00, 2'b00);
    btn_raw = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t6_window", k, 2'b00, 2'b00);
    end
    for (int o = 0; o <= 30; o++) begin
      if (o == 18) btn_raw = 2'b00;
      step();
      exp_l = (o < 23) ? 2'b01 : 2'b00;
`ifdef BTN_AUTOREPEAT_EN
      exp_p = (o == 0 || o == 8 || o == 11 || o == 14 || o == 17 || o == 20)
              ? 2'b01 : 2'b00;
`else
      exp_p = (o == 0) ? 2'b01 : 2'b00;
`endif
      check("t6_hold", o, exp_l, exp_p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
